alarm_ring_ctrl: RTL

Sequencing controller for the alarm path of the digital clock. It holds the programmed alarm time, detects the alarm instant against the running BCD time, and drives the buzzer and light. It also implements snooze with a bounded retry count, ring timeout and stop handling. It sits between the time counter / setting logic and the buzzer/LED drivers, and replaces the simple combinational alarm compare with a registered state machine.

---
 rtl/alarm_ring_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencing controller: holds the programmed alarm, detects the alarm
// instant against the running BCD time, and drives buzzer/LED with snooze/stop.
module alarm_ring_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        CP,
  input  logic        CR,
  input  logic        tick_1hz,
  input  logic [7:0]  show_hour,
  input  logic [7:0]  show_min,
  input  logic [7:0]  show_sec,
  input  logic [7:0]  pre_hour,
  input  logic [7:0]  pre_min,
  input  logic        PE,
  input  logic        active_alarm,
  input  logic        snooze_btn,
  input  logic        stop_btn,
  output logic        ring,
  output logic        light,
  output logic [1:0]  state,
  output logic [1:0]  snooze_cnt,
  output logic [15:0] target_time
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ARMED   = 2'b01;
  localparam logic [1:0] ST_RINGING = 2'b10;
  localparam logic [1:0] ST_SNOOZE  = 2'b11;

  localparam logic [7:0] RING_SEC_L   = 8'(RING_SEC);
  localparam logic [3:0] SNOOZE_MIN_L = 4'(SNOOZE_MIN);
  localparam logic [1:0] MAX_SNOOZE_L = 2'(MAX_SNOOZE);

  logic [15:0] base;
  logic [7:0]  timer;
  logic        phase;
  logic        match_d;

  logic        match;
  logic        match_rise;
  logic        timeout;

  logic [1:0]  nxt_state;
  logic [1:0]  nxt_cnt;
  logic [15:0] nxt_target;
  logic [15:0] nxt_base;
  logic [7:0]  nxt_timer;
  logic        nxt_phase;

  // Adds the snooze delay to a {hour,min} BCD time, wrapping 23:59 -> 00:xx.
  function automatic logic [15:0] bcd_add_snooze(input logic [15:0] t);
    logic [4:0] min_lo;
    logic [3:0] min_hi;
    logic [3:0] hr_hi;
    logic [3:0] hr_lo;
    logic       hr_carry;
    min_lo   = {1'b0, t[3:0]} + {1'b0, SNOOZE_MIN_L};
    min_hi   = t[7:4];
    hr_hi    = t[15:12];
    hr_lo    = t[11:8];
    hr_carry = 1'b0;
    if (min_lo > 5'd9) begin
      min_lo = min_lo - 5'd10;
      min_hi = min_hi + 4'd1;
    end
    if (min_hi >= 4'd6) begin
      min_hi   = min_hi - 4'd6;
      hr_carry = 1'b1;
    end
    if (hr_carry) begin
      if (hr_hi == 4'd2 && hr_lo == 4'd3) begin
        hr_hi = 4'd0;
        hr_lo = 4'd0;
      end else if (hr_lo == 4'd9) begin
        hr_lo = 4'd0;
        hr_hi = hr_hi + 4'd1;
      end else begin
        hr_lo = hr_lo + 4'd1;
      end
    end
    return {hr_hi, hr_lo, min_hi, min_lo[3:0]};
  endfunction

  assign match      = ({show_hour, show_min} == target_time) && (show_sec == 8'h00);
  assign match_rise = match & ~match_d;
  assign timeout    = (timer == RING_SEC_L);

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = snooze_cnt;
    nxt_target = target_time;
    nxt_base   = base;
    nxt_timer  = timer;
    nxt_phase  = phase;
    if (PE) begin
      nxt_base   = {pre_hour, pre_min};
      nxt_target = {pre_hour, pre_min};
      nxt_cnt    = 2'd0;
      nxt_timer  = 8'd0;
      nxt_phase  = 1'b0;
      nxt_state  = active_alarm ? ST_ARMED : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (active_alarm) nxt_state = ST_ARMED;
        end
        ST_ARMED: begin
          if (!active_alarm) begin
            nxt_state = ST_IDLE;
          end else if (match_rise) begin
            nxt_state = ST_RINGING;
            nxt_timer = 8'd0;
            nxt_phase = 1'b1;
          end
        end
        ST_RINGING: begin
          // A timeout is handled exactly like a stop press.
          if (stop_btn || timeout) begin
            nxt_state  = ST_ARMED;
            nxt_target = base;
            nxt_cnt    = 2'd0;
          end else if (!active_alarm) begin
            nxt_state  = ST_IDLE;
            nxt_target = base;
            nxt_cnt    = 2'd0;
          end else if (snooze_btn && (snooze_cnt < MAX_SNOOZE_L)) begin
            nxt_state  = ST_SNOOZE;
            nxt_cnt    = snooze_cnt + 2'd1;
            nxt_target = bcd_add_snooze(target_time);
          end else if (tick_1hz) begin
            nxt_timer = timer + 8'd1;
            nxt_phase = ~phase;
          end
        end
        default: begin
          if (stop_btn) begin
            nxt_state  = ST_ARMED;
            nxt_target = base;
            nxt_cnt    = 2'd0;
          end else if (!active_alarm) begin
            nxt_state  = ST_IDLE;
            nxt_target = base;
            nxt_cnt    = 2'd0;
          end else if (match_rise) begin
            nxt_state = ST_RINGING;
            nxt_timer = 8'd0;
            nxt_phase = 1'b1;
          end
        end
      endcase
    end
  end

  // ring/light are derived from the next state so they move on the same edge.
  always_ff @(posedge CP) begin
    if (CR) begin
      state       <= ST_IDLE;
      ring        <= 1'b0;
      light       <= 1'b0;
      snooze_cnt  <= 2'd0;
      target_time <= 16'h0000;
      base        <= 16'h0000;
      timer       <= 8'd0;
      match_d     <= 1'b0;
      phase       <= 1'b0;
    end else begin
      state       <= nxt_state;
      ring        <= (nxt_state == ST_RINGING) & nxt_phase;
      light       <= (nxt_state == ST_RINGING);
      snooze_cnt  <= nxt_cnt;
      target_time <= nxt_target;
      base        <= nxt_base;
      timer       <= nxt_timer;
      match_d     <= match;
      phase       <= nxt_phase;
    end
  end

endmodule
